// File: rtl/mul_issue_pkg.sv
// Shared types and default constants for the multiplier issue controller.
// The optional watchdog is enabled with the MUL_ISSUE_TIMEOUT_EN macro (see mul_issue_ctrl).
package mul_issue_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } mul_state_e;

    // Operand pair at the default width; the FIFO word uses the same {a, b} order.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mul_issue_fifo.sv
// Synchronous FIFO of operand pairs with count-based full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module mul_issue_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller: queues operand pairs, starts the multiplier one job at a time, holds tagged results.
// Define MUL_ISSUE_TIMEOUT_EN to enable the WAIT-state watchdog and the sticky err_timeout flag.
module mul_issue_ctrl
    import mul_issue_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = 2 * WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_in_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [OUT_WIDTH-1:0] mul_o,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 err_timeout,
    output mul_state_e           dbg_state
);

    // Elaboration-time parameter sanity.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mul_issue_ctrl: DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mul_issue_ctrl: TIMEOUT must be at least 1");
    end

    // Handshakes: the producer side transfers when in_valid && in_ready on a rising edge;
    // the result side transfers when res_valid && res_ready. The multiplier side has no
    // ready: mul_in_valid is a single-cycle start pulse and mul_done is trusted only in WAIT.

    mul_state_e             r_state;
    mul_state_e             w_next;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_full;
    logic                   w_empty;
    logic [2*WIDTH-1:0]     w_head;
    logic [WIDTH-1:0]       r_mul_a;
    logic [WIDTH-1:0]       r_mul_b;
    logic [OUT_WIDTH-1:0]   r_res_data;
    logic [TAG_W-1:0]       r_res_tag;
    logic [TAG_W-1:0]       r_tag_cnt;
    logic [TAG_W-1:0]       r_issue_tag;

    mul_issue_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  ({in_a, in_b}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;
    logic            w_timeout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
`ifdef MUL_ISSUE_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (mul_done) begin
                    w_capture = 1'b1;
                    w_next    = HOLD;
                end
`ifdef MUL_ISSUE_TIMEOUT_EN
                else if (r_wd_cnt == WD_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
`endif
            end
            HOLD: begin
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_tag_cnt   <= '0;
            r_issue_tag <= '0;
        end else begin
            if (w_pop) begin
                r_mul_a <= w_head[2*WIDTH-1:WIDTH];
                r_mul_b <= w_head[WIDTH-1:0];
            end
            // The tag is consumed at issue, so an abandoned job still advances the sequence.
            if (r_state == ISSUE) begin
                r_issue_tag <= r_tag_cnt;
                r_tag_cnt   <= r_tag_cnt + 1'b1;
            end
            if (w_capture) begin
                r_res_data <= mul_o;
                r_res_tag  <= r_issue_tag;
            end
        end
    end

`ifdef MUL_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == WAIT) r_wd_cnt <= r_wd_cnt + 1'b1;
            else                 r_wd_cnt <= '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign err_timeout = r_err;
`else
    assign err_timeout = 1'b0;
`endif

    assign in_ready     = !w_full;
    assign mul_in_valid = (r_state == ISSUE);
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign res_valid    = (r_state == HOLD);
    assign res_data     = r_res_data;
    assign res_tag      = r_res_tag;
    assign dbg_state    = r_state;

endmodule
